ultrasonic_distance_filter: RTL and testbench

- Sits directly downstream of ultra_sonic and consumes its echo pulse-width measurement (read_data / read_data_valid, in clock cycles).
- Converts each width to centimetres using a sequential constant divider, then rejects out-of-range samples.
- Averages the accepted samples over a power-of-two window and raises a hysteretic near-obstacle alarm.
- Exposes distance and status to the Nios through a read-only, latency-1 Avalon-MM slave.

---
 rtl/ultrasonic_pkg.sv | 21 ++
 rtl/ultrasonic_distance_filter_seq_divider.sv | 52 +++++
 rtl/ultrasonic_distance_filter.sv | 145 ++++++++++++++
 tb/tb_ultrasonic_distance_filter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/ultrasonic_pkg.sv
// rtl/ultrasonic_pkg.sv - shared types and register map for the ultrasonic distance filter
package ultrasonic_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIVIDE = 2'd1,
    S_CHECK  = 2'd2,
    S_UPDATE = 2'd3
  } state_t;

  localparam logic ADDR_DISTANCE = 1'b0;
  localparam logic ADDR_STATUS   = 1'b1;

  localparam int BUSY       = 0;
  localparam int NEAR       = 1;
  localparam int OVERRUN    = 2;
  localparam int FULL       = 3;
  localparam int REJECT_LSB = 16;
  localparam int REJECT_MSB = 31;

endpackage

// File: rtl/ultrasonic_distance_filter_seq_divider.sv
// rtl/ultrasonic_distance_filter_seq_divider.sv - 32-cycle restoring divider by a constant
module seq_divider #(
  parameter int unsigned DIVISOR = 2900
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dividend,
  output logic        done,
  output logic [31:0] quotient
);

  localparam logic [32:0] DIV33 = 33'(DIVISOR);

  logic [31:0] quo;
  logic [31:0] rem;
  logic [4:0]  cnt;
  logic        active;
  logic [32:0] rem_sh;
  logic [32:0] diff;
  logic        fits;

  always_comb begin
    rem_sh = {rem, quo[31]};
    diff   = rem_sh - DIV33;
    fits   = (rem_sh >= DIV33);
  end

  // The dividend is shifted out of quo while quotient bits shift in.
  always_ff @(posedge clk) begin
    if (reset) begin
      quo    <= '0;
      rem    <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (start) begin
      quo    <= dividend;
      rem    <= '0;
      cnt    <= '0;
      active <= 1'b1;
    end else if (active) begin
      quo <= {quo[30:0], fits};
      rem <= fits ? diff[31:0] : rem_sh[31:0];
      cnt <= cnt + 5'd1;
      if (cnt == 5'd31) active <= 1'b0;
    end
  end

  assign done     = active && (cnt == 5'd31);
  assign quotient = quo;

endmodule

// File: rtl/ultrasonic_distance_filter.sv
// rtl/ultrasonic_distance_filter.sv - echo width to cm, range check, window average, near alarm
module ultrasonic_distance_filter
  import ultrasonic_pkg::*;
#(
  parameter int unsigned CYCLES_PER_CM = 2900,
  parameter int unsigned MAX_CM        = 400,
  parameter int unsigned AVG_LOG2      = 2,
  parameter int unsigned NEAR_CM       = 20,
  parameter int unsigned HYST_CM       = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] echo_cycles,
  input  logic        echo_valid,
  input  logic        avs_address,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  output logic        avs_readdatavalid,
  output logic [15:0] distance_cm,
  output logic        distance_valid,
  output logic        near_alarm
);

  localparam int unsigned WIN   = 1 << AVG_LOG2;
  localparam int unsigned SUM_W = 16 + AVG_LOG2;
  localparam logic [AVG_LOG2:0] WIN_CNT = (AVG_LOG2 + 1)'(WIN);

  state_t state, state_next;

  logic        div_start, div_done;
  logic [31:0] quotient;
  logic        out_of_range;
  logic        do_reject, do_update;

  logic [15:0]         ring [WIN];
  logic [AVG_LOG2-1:0] wr_ptr;
  logic [AVG_LOG2:0]   fill, fill_next;
  logic [SUM_W-1:0]    sum, sum_next;
  logic [15:0]         sample_cm, dist_next;
  logic [15:0]         reject_count;
  logic                overrun;
  logic                rd_status;
  logic [31:0]         status_word;

  seq_divider #(.DIVISOR(CYCLES_PER_CM)) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (echo_cycles),
    .done     (div_done),
    .quotient (quotient)
  );

  assign out_of_range = (quotient == 32'd0) || (quotient > 32'(MAX_CM));

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (echo_valid) state_next = S_DIVIDE;
      S_DIVIDE: if (div_done) state_next = S_CHECK;
      S_CHECK:  state_next = out_of_range ? S_IDLE : S_UPDATE;
      S_UPDATE: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    div_start = (state == S_IDLE) && echo_valid;
    do_reject = (state == S_CHECK) && out_of_range;
    do_update = (state == S_UPDATE);
  end

  // Oldest slot reads zero until the window has filled, so the running sum stays exact.
  always_comb begin
    sum_next  = sum + SUM_W'(sample_cm) - SUM_W'(ring[wr_ptr]);
    fill_next = (fill == WIN_CNT) ? fill : fill + 1'b1;
    dist_next = (fill_next == WIN_CNT) ? 16'(sum_next >> AVG_LOG2) : sample_cm;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(WIN); i++) ring[i] <= '0;
      wr_ptr         <= '0;
      fill           <= '0;
      sum            <= '0;
      sample_cm      <= '0;
      distance_cm    <= '0;
      distance_valid <= 1'b0;
      near_alarm     <= 1'b0;
      reject_count   <= '0;
    end else begin
      distance_valid <= 1'b0;
      if (state == S_CHECK) sample_cm <= quotient[15:0];
      if (do_reject && reject_count != 16'hFFFF) reject_count <= reject_count + 16'd1;
      if (do_update) begin
        ring[wr_ptr]   <= sample_cm;
        wr_ptr         <= wr_ptr + 1'b1;
        fill           <= fill_next;
        sum            <= sum_next;
        distance_cm    <= dist_next;
        distance_valid <= 1'b1;
        if (dist_next < 16'(NEAR_CM))
          near_alarm <= 1'b1;
        else if (dist_next >= 16'(NEAR_CM + HYST_CM))
          near_alarm <= 1'b0;
      end
    end
  end

  assign rd_status = avs_read && (avs_address == ADDR_STATUS);

  // A new overrun wins over a clearing status read in the same cycle.
  always_ff @(posedge clk) begin
    if (reset)                               overrun <= 1'b0;
    else if (echo_valid && state != S_IDLE) overrun <= 1'b1;
    else if (rd_status)                      overrun <= 1'b0;
  end

  always_comb begin
    status_word = '0;
    status_word[REJECT_MSB:REJECT_LSB] = reject_count;
    status_word[FULL]    = (fill == WIN_CNT);
    status_word[OVERRUN] = overrun;
    status_word[NEAR]    = near_alarm;
    status_word[BUSY]    = (state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      avs_readdatavalid <= 1'b0;
      avs_readdata      <= '0;
    end else begin
      avs_readdatavalid <= avs_read;
      if (!avs_read)                          avs_readdata <= '0;
      else if (avs_address == ADDR_DISTANCE) avs_readdata <= {16'b0, distance_cm};
      else                                    avs_readdata <= status_word;
    end
  end

endmodule

// File: tb/tb_ultrasonic_distance_filter.sv
// tb/tb_ultrasonic_distance_filter.sv - directed vector bench for ultrasonic_distance_filter
module tb_ultrasonic_distance_filter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] echo_cycles;
  logic        echo_valid;
  logic        avs_address;
  logic        avs_read;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic [15:0] distance_cm;
  logic        distance_valid;
  logic        near_alarm;

  ultrasonic_distance_filter dut (
    .clk               (clk),
    .reset             (reset),
    .echo_cycles       (echo_cycles),
    .echo_valid        (echo_valid),
    .avs_address       (avs_address),
    .avs_read          (avs_read),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .distance_cm       (distance_cm),
    .distance_valid    (distance_valid),
    .near_alarm        (near_alarm)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] echo;
    bit          exp_valid;
    logic [15:0] exp_dist;
    bit          exp_near;
    bit          exp_full;
    logic [15:0] exp_rej;
  } vec_t;

  vec_t vecs [21];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge; pulses echo_valid, optionally a second one at cycle 'second_at'.
  task automatic run_echo(input logic [31:0] e, input int second_at,
                          output bit seen, output int lat, output logic [15:0] d);
    seen = 0; lat = 0; d = '0;
    echo_cycles = e;
    echo_valid  = 1'b1;
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      echo_valid = (second_at != 0 && n == second_at);
      if (distance_valid && !seen) begin
        seen = 1; lat = n; d = distance_cm;
      end
    end
  endtask

  task automatic avs_rd(input logic addr, output logic vld, output logic [31:0] data);
    avs_address = addr;
    avs_read    = 1'b1;
    @(negedge clk);
    avs_read = 1'b0;
    vld  = avs_readdatavalid;
    data = avs_readdata;
  endtask

  bit          seen;
  int          lat;
  logic [15:0] d;
  logic        vld;
  logic [31:0] rd;
  logic [31:0] rd2;

  initial begin
    vecs[0]  = '{32'd29000,   1, 16'd10,  1, 0, 16'd0};
    vecs[1]  = '{32'd58000,   1, 16'd20,  1, 0, 16'd0};
    vecs[2]  = '{32'd87000,   1, 16'd30,  0, 0, 16'd0};
    vecs[3]  = '{32'd116000,  1, 16'd25,  0, 1, 16'd0};
    vecs[4]  = '{32'd0,       0, 16'd25,  0, 1, 16'd1};
    vecs[5]  = '{32'd1450000, 0, 16'd25,  0, 1, 16'd2};
    vecs[6]  = '{32'd1160000, 1, 16'd122, 0, 1, 16'd2};
    vecs[7]  = '{32'd1162900, 0, 16'd122, 0, 1, 16'd3};
    vecs[8]  = '{32'd2899,    0, 16'd122, 0, 1, 16'd4};
    vecs[9]  = '{32'd43500,   1, 16'd121, 0, 1, 16'd4};
    vecs[10] = '{32'd43500,   1, 16'd117, 0, 1, 16'd4};
    vecs[11] = '{32'd43500,   1, 16'd111, 0, 1, 16'd4};
    vecs[12] = '{32'd43500,   1, 16'd15,  1, 1, 16'd4};
    vecs[13] = '{32'd63800,   1, 16'd16,  1, 1, 16'd4};
    vecs[14] = '{32'd63800,   1, 16'd18,  1, 1, 16'd4};
    vecs[15] = '{32'd63800,   1, 16'd20,  1, 1, 16'd4};
    vecs[16] = '{32'd63800,   1, 16'd22,  1, 1, 16'd4};
    vecs[17] = '{32'd75400,   1, 16'd23,  1, 1, 16'd4};
    vecs[18] = '{32'd75400,   1, 16'd24,  1, 1, 16'd4};
    vecs[19] = '{32'd75400,   1, 16'd25,  0, 1, 16'd4};
    vecs[20] = '{32'd75400,   1, 16'd26,  0, 1, 16'd4};

    reset = 1'b1; echo_cycles = '0; echo_valid = 1'b0; avs_address = 1'b0; avs_read = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("reset_dist", {16'b0, distance_cm}, 32'd0);
    check("reset_near", {31'b0, near_alarm}, 32'd0);
    check("reset_dvalid", {31'b0, distance_valid}, 32'd0);
    check("reset_rdata", avs_readdata, 32'd0);
    avs_rd(1'b1, vld, rd);
    check("reset_status", rd, 32'd0);

    for (int i = 0; i < 21; i++) begin
      run_echo(vecs[i].echo, 0, seen, lat, d);
      check($sformatf("v%0d_valid", i), {31'b0, seen}, {31'b0, vecs[i].exp_valid});
      if (vecs[i].exp_valid) begin
        check($sformatf("v%0d_latency", i), lat, 35);
        check($sformatf("v%0d_dist_strobe", i), {16'b0, d}, {16'b0, vecs[i].exp_dist});
      end
      check($sformatf("v%0d_dist", i), {16'b0, distance_cm}, {16'b0, vecs[i].exp_dist});
      check($sformatf("v%0d_near", i), {31'b0, near_alarm}, {31'b0, vecs[i].exp_near});
      avs_rd(1'b1, vld, rd);
      check($sformatf("v%0d_rdvalid", i), {31'b0, vld}, 32'd1);
      check($sformatf("v%0d_status", i), rd,
            {vecs[i].exp_rej, 12'b0, vecs[i].exp_full, 1'b0, vecs[i].exp_near, 1'b0});
    end

    // Second echo during DIVIDE is dropped and flags overrun; window [26,10,26,26] -> 22.
    run_echo(32'd29000, 10, seen, lat, d);
    check("ovr_latency", lat, 35);
    check("ovr_dist", {16'b0, d}, 32'd22);
    avs_address = 1'b1;
    avs_read    = 1'b1;
    @(negedge clk);
    rd = avs_readdata;
    check("b2b_valid1", {31'b0, avs_readdatavalid}, 32'd1);
    @(negedge clk);
    rd2 = avs_readdata;
    check("b2b_valid2", {31'b0, avs_readdatavalid}, 32'd1);
    avs_read = 1'b0;
    check("ovr_status_set", rd, {16'd4, 12'b0, 4'b1100});
    check("ovr_status_clr", rd2, {16'd4, 12'b0, 4'b1000});
    @(negedge clk);
    check("idle_rdvalid", {31'b0, avs_readdatavalid}, 32'd0);
    check("idle_rdata", avs_readdata, 32'd0);
    avs_rd(1'b0, vld, rd);
    check("addr0_dist", rd, 32'd22);

    // Busy bit during a division.
    echo_cycles = 32'd29000;
    echo_valid  = 1'b1;
    @(negedge clk);
    echo_valid = 1'b0;
    repeat (4) @(negedge clk);
    avs_rd(1'b1, vld, rd);
    check("busy_status", rd, {16'd4, 12'b0, 4'b1001});
    repeat (40) @(negedge clk);

    // Reset asserted in the 20th DIVIDE cycle.
    echo_cycles = 32'd58000;
    echo_valid  = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      echo_valid = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_dist", {16'b0, distance_cm}, 32'd0);
    check("rst_mid_near", {31'b0, near_alarm}, 32'd0);
    check("rst_mid_dvalid", {31'b0, distance_valid}, 32'd0);
    avs_rd(1'b1, vld, rd);
    check("rst_mid_status", rd, 32'd0);
    run_echo(32'd29000, 0, seen, lat, d);
    check("post_rst_latency", lat, 35);
    check("post_rst_dist", {16'b0, d}, 32'd10);
    avs_rd(1'b1, vld, rd);
    check("post_rst_status", rd, 32'h0000_0002);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
